// File: rtl/msch_pkg.sv
// Shared constants and FSM state encoding for the message-schedule controller.
`timescale 1ns/1ps
package msch_pkg;

  localparam int ROUNDS_DEF = 64;
  localparam int RND_W_DEF  = 6;

  typedef logic [1:0] msch_state_t;

  localparam msch_state_t IDLE = 2'd0;
  localparam msch_state_t RUN  = 2'd1;
  localparam msch_state_t DONE = 2'd2;

endpackage

// File: rtl/msch_rnd_cnt.sv
// Round index counter: clears on block load, advances on each consumed word, flags ROUNDS-1.
`timescale 1ns/1ps
module msch_rnd_cnt #(
  parameter int ROUNDS = 64,
  parameter int RND_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [RND_W-1:0] rnd,
  output logic             tc
);

  localparam logic [RND_W-1:0] LAST = RND_W'(ROUNDS - 1);

  assign tc = (rnd == LAST);

  // Holding at LAST keeps the index inside the block even if en is misused.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rnd <= '0;
    end else if (en && !tc) begin
      rnd <= rnd + 1'b1;
    end
  end

endmodule

// File: rtl/msch_ctrl.sv
// Message-schedule sequencing controller; optional done-pulse counter on blk_cnt
// when MSCH_CTRL_BLK_CNT_EN is defined.
`timescale 1ns/1ps
module msch_ctrl
  import msch_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int RND_W  = RND_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blk_vld,
  output logic             blk_rdy,
  input  logic             stall,
  output logic             ld_mreg,
  output logic             upd_mreg,
  output logic [RND_W-1:0] rnd,
  output logic             w_vld,
  output logic             done
`ifdef MSCH_CTRL_BLK_CNT_EN
  ,
  output logic [15:0]      blk_cnt
`endif
);

  // state | meaning
  // IDLE  | ready for a block; handshake loads the word registers
  // RUN   | W[rnd] valid on m0; each unstalled cycle consumes one word
  // DONE  | one-cycle completion pulse, then back to IDLE

  msch_state_t state;
  msch_state_t state_nxt;
  logic        tc;

  always_comb begin
    blk_rdy   = 1'b0;
    ld_mreg   = 1'b0;
    upd_mreg  = 1'b0;
    w_vld     = 1'b0;
    done      = 1'b0;
    state_nxt = state;
    if (!rst) begin
      case (state)
        IDLE: begin
          blk_rdy = 1'b1;
          if (blk_vld) begin
            ld_mreg   = 1'b1;
            upd_mreg  = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          w_vld = 1'b1;
          // Last word consumed without a shift: registers keep W[ROUNDS-1].
          if (!stall) begin
            if (tc) begin
              state_nxt = DONE;
            end else begin
              upd_mreg = 1'b1;
            end
          end
        end
        DONE: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  msch_rnd_cnt #(
    .ROUNDS(ROUNDS),
    .RND_W (RND_W)
  ) u_rnd_cnt (
    .clk(clk),
    .rst(rst),
    .clr(ld_mreg),
    .en (upd_mreg & ~ld_mreg),
    .rnd(rnd),
    .tc (tc)
  );

`ifdef MSCH_CTRL_BLK_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (done) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msch_ctrl.sv
// Directed bench: msch_ctrl driving a SHA-256 message-schedule shift register model.
`timescale 1ns/1ps
module tb_msch_ctrl;
  import msch_pkg::*;

  localparam int ROUNDS = 64;
  localparam int RND_W  = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             blk_vld = 1'b0;
  logic             stall = 1'b0;
  logic [511:0]     blk = '0;
  logic             blk_rdy, ld_mreg, upd_mreg, w_vld, done;
  logic [RND_W-1:0] rnd;
`ifdef MSCH_CTRL_BLK_CNT_EN
  logic [15:0]      blk_cnt;
  int               exp_cnt = 0;
`endif

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  int a_cyc, n_stall, a_first, k;

  logic [31:0]  mreg [16];
  logic [31:0]  gold [64];
  logic [31:0]  obs  [64];
  logic [511:0] b1, b2;

  msch_ctrl #(.ROUNDS(ROUNDS), .RND_W(RND_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .blk_vld (blk_vld),
    .blk_rdy (blk_rdy),
    .stall   (stall),
    .ld_mreg (ld_mreg),
    .upd_mreg(upd_mreg),
    .rnd     (rnd),
    .w_vld   (w_vld),
    .done    (done)
`ifdef MSCH_CTRL_BLK_CNT_EN
    ,
    .blk_cnt (blk_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Datapath: 16 word registers, m0 = mreg[0]
  always @(posedge clk) begin
    if (upd_mreg) begin
      if (ld_mreg) begin
        for (int i = 0; i < 16; i++) mreg[i] <= blk[511-32*i -: 32];
      end else begin
        for (int i = 0; i < 15; i++) mreg[i] <= mreg[i+1];
        mreg[15] <= ssig1(mreg[14]) + mreg[9] + ssig0(mreg[1]) + mreg[0];
      end
    end
  end

  task automatic fill_gold(input logic [511:0] b);
    for (int t = 0; t < 16; t++) gold[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      gold[t] = ssig1(gold[t-2]) + gold[t-7] + ssig0(gold[t-15]) + gold[t-16];
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic send_block(input logic [511:0] b, input int per, input bit hold);
    int  waitc, kk, er;
    bit  fin;
    fill_gold(b);
    blk = b; blk_vld = 1'b1; stall = 1'b0;
    #1;
    waitc = 0;
    while (!blk_rdy && waitc < 200) begin
      @(negedge clk); #1; waitc++;
    end
    chk("hs_blk_rdy", 32'(blk_rdy), 32'd1);
    chk("hs_ld_mreg", 32'(ld_mreg), 32'd1);
    chk("hs_upd_mreg", 32'(upd_mreg), 32'd1);
    chk("hs_w_vld", 32'(w_vld), 32'd0);
    a_cyc = cyc;
    @(negedge clk);
    if (!hold) blk_vld = 1'b0;
    er = 0; kk = 0; fin = 1'b0; n_stall = 0;
    while (!fin && kk < 300) begin
      stall = (per != 0) && ((kk % per) == per - 1);
      #1;
      chk("run_rnd", 32'(rnd), 32'(er));
      chk("run_w_vld", 32'(w_vld), 32'd1);
      chk("run_blk_rdy", 32'(blk_rdy), 32'd0);
      chk("run_ld_mreg", 32'(ld_mreg), 32'd0);
      chk("run_done", 32'(done), 32'd0);
      chk("run_m0", mreg[0], gold[er]);
      chk("run_upd_mreg", 32'(upd_mreg), 32'(!stall && er < ROUNDS - 1));
      obs[er] = mreg[0];
      if (stall) n_stall++;
      else if (er == ROUNDS - 1) fin = 1'b1;
      else er++;
      kk++;
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("run_bound", 32'(fin), 32'd1);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_w_vld", 32'(w_vld), 32'd0);
    chk("done_blk_rdy", 32'(blk_rdy), 32'd0);
    chk("done_ld_mreg", 32'(ld_mreg), 32'd0);
    chk("done_upd_mreg", 32'(upd_mreg), 32'd0);
    chk("done_latency", 32'(cyc - a_cyc), 32'(ROUNDS + 1 + n_stall));
    @(negedge clk);
`ifdef MSCH_CTRL_BLK_CNT_EN
    exp_cnt++;
    chk("blk_cnt", 32'(blk_cnt), 32'(exp_cnt));
`endif
  endtask

  initial begin
    b1 = {32'h61626364, 32'h30313233, 32'h80000000, 384'h0, 32'h00000040};
    b2 = {32'h61626380, 448'h0, 32'h00000018};

    // Reset held with blk_vld high: everything masked
    rst = 1'b1; blk_vld = 1'b1; blk = b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_blk_rdy", 32'(blk_rdy), 32'd0);
    chk("rst_ld_mreg", 32'(ld_mreg), 32'd0);
    chk("rst_upd_mreg", 32'(upd_mreg), 32'd0);
    chk("rst_w_vld", 32'(w_vld), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0; blk_vld = 1'b0;
    #1;
    chk("idle_blk_rdy", 32'(blk_rdy), 32'd1);
    chk("idle_ld_mreg", 32'(ld_mreg), 32'd0);
    chk("idle_upd_mreg", 32'(upd_mreg), 32'd0);
    chk("idle_rnd", 32'(rnd), 32'd0);
    chk("idle_w_vld", 32'(w_vld), 32'd0);
`ifdef MSCH_CTRL_BLK_CNT_EN
    chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
`endif
    @(negedge clk);

    // Padded "abcd0123", no stall
    send_block(b1, 0, 1'b0);
    chk("abcd_w0", obs[0], 32'h61626364);
    chk("abcd_w1", obs[1], 32'h30313233);
    chk("abcd_w2", obs[2], 32'h80000000);
    chk("abcd_w15", obs[15], 32'h00000040);
    #1;
    chk("post_idle_blk_rdy", 32'(blk_rdy), 32'd1);
    @(negedge clk);

    // Same block with one stall in every three RUN cycles
    send_block(b1, 3, 1'b0);
    chk("stall_count", 32'(n_stall), 32'd31);

    // blk_vld held: back-to-back blocks
    send_block(b1, 0, 1'b1);
    a_first = a_cyc;
    send_block(b2, 0, 1'b0);
    chk("b2b_gap", 32'(a_cyc - a_first), 32'd66);
    chk("abc_w0", obs[0], 32'h61626380);
    chk("abc_w15", obs[15], 32'h00000018);
    chk("abc_w16", obs[16], 32'h61626380);

    // Reset pulse at rnd=20
    blk = b1; blk_vld = 1'b1;
    #1;
    k = 0;
    while (!blk_rdy && k < 200) begin @(negedge clk); #1; k++; end
    @(negedge clk);
    blk_vld = 1'b0;
    #1;
    k = 0;
    while (rnd != 6'd20 && k < 200) begin @(negedge clk); #1; k++; end
    chk("mid_reach_rnd20", 32'(rnd), 32'd20);
    rst = 1'b1;
    #1;
    chk("mid_rst_w_vld", 32'(w_vld), 32'd0);
    chk("mid_rst_upd_mreg", 32'(upd_mreg), 32'd0);
    chk("mid_rst_blk_rdy", 32'(blk_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef MSCH_CTRL_BLK_CNT_EN
    exp_cnt = 0;
`endif
    #1;
    chk("mid_post_rnd", 32'(rnd), 32'd0);
    chk("mid_post_w_vld", 32'(w_vld), 32'd0);
    chk("mid_post_blk_rdy", 32'(blk_rdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("mid_no_done", 32'(done), 32'd0);
      chk("mid_idle_w_vld", 32'(w_vld), 32'd0);
    end
    @(negedge clk);
    send_block(b1, 0, 1'b0);
    chk("recover_w63", obs[63], gold[63]);

`ifdef MSCH_CTRL_BLK_CNT_EN
    send_block(b2, 0, 1'b0);
    send_block(b1, 0, 1'b0);
    chk("blk_cnt_three", 32'(blk_cnt), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("blk_cnt_rst", 32'(blk_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
